// File: rtl/sample_slot_arbiter_if.sv
// Shared sampling port between four requesters and the slot arbiter.
// The arbiter side uses the slave modport, requesters the master modport.
interface sample_slot_arbiter_if;
  logic [3:0]  req;
  logic [3:0]  x;
  logic [63:0] d_bus;
  logic [3:0]  ack;
  logic        upd;
  logic [1:0]  gnt_id;
  logic [3:0]  a3_a0;
  logic [7:0]  z7_z0;
  logic [7:0]  idle_slots;

  modport master (
    output req,
    output x,
    output d_bus,
    input  ack,
    input  upd,
    input  gnt_id,
    input  a3_a0,
    input  z7_z0,
    input  idle_slots
  );

  modport slave (
    input  req,
    input  x,
    input  d_bus,
    output ack,
    output upd,
    output gnt_id,
    output a3_a0,
    output z7_z0,
    output idle_slots
  );
endinterface

// File: rtl/sample_slot_arbiter.sv
// Periodic round-robin slot scheduler for a shared nibble/byte port.
// One grant per PERIOD enabled cycles; all outputs are registered.
module sample_slot_arbiter #(
  parameter int unsigned PERIOD = 10
) (
  input  logic                  clock,
  input  logic                  reset_,
  input  logic                  en,
  sample_slot_arbiter_if.slave  bus
);

  localparam int unsigned CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t RELOAD = cnt_t'(PERIOD - 1);

  cnt_t        count_q, count_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  ack_q, ack_d;
  logic        upd_q, upd_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [3:0]  a_q, a_d;
  logic [7:0]  z_q, z_d;
  logic [7:0]  idle_q, idle_d;

  logic        slot;
  logic        hit;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic [15:0] sel_w;

  assign slot = en && (count_q == '0);

  // Scan last+1 .. last+4 (mod 4); the first set request wins.
  always_comb begin
    pick = last_q;
    hit  = 1'b0;
    idx  = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!hit && bus.req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  assign sel_w = bus.d_bus[16*pick +: 16];

  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    ack_d   = '0;
    upd_d   = 1'b0;
    gnt_d   = gnt_q;
    a_d     = a_q;
    z_d     = z_q;
    idle_d  = idle_q;
    if (en) begin
      count_d = slot ? RELOAD : count_q - cnt_t'(1);
    end
    if (slot) begin
      if (hit) begin
        a_d    = bus.x[pick] ? sel_w[11:8] : sel_w[15:12];
        z_d    = sel_w[7:0];
        gnt_d  = pick;
        last_d = pick;
        ack_d  = 4'b0001 << pick;
        upd_d  = 1'b1;
      end else if (idle_q != 8'hFF) begin
        idle_d = idle_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_) begin
      count_q <= RELOAD;
      last_q  <= 2'd3;
      ack_q   <= '0;
      upd_q   <= 1'b0;
      gnt_q   <= '0;
      a_q     <= '0;
      z_q     <= '0;
      idle_q  <= '0;
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      upd_q   <= upd_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      z_q     <= z_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.upd        = upd_q;
  assign bus.gnt_id     = gnt_q;
  assign bus.a3_a0      = a_q;
  assign bus.z7_z0      = z_q;
  assign bus.idle_slots = idle_q;

endmodule

// File: tb/tb_sample_slot_arbiter.sv
// Scoreboard bench for sample_slot_arbiter: per-edge expectations from a
// slot-counting reference model, checked by an independent negedge monitor.
module tb_sample_slot_arbiter;

  localparam int P = 10;

  logic clock = 1'b0;
  logic reset_;
  logic en;

  sample_slot_arbiter_if bus ();

  sample_slot_arbiter #(.PERIOD(P)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .en     (en),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] ack;
    logic       upd;
    logic [1:0] gnt;
    logic [3:0] a;
    logic [7:0] z;
    logic [7:0] idle;
  } exp_t;

  exp_t  expq[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  string phase = "init";

  int         m_en_cnt = 0;
  int         m_last   = 3;
  int         m_idle   = 0;
  logic [3:0] m_ack    = '0;
  logic       m_upd    = 1'b0;
  logic [1:0] m_g      = '0;
  logic [3:0] m_a      = '0;
  logic [7:0] m_z      = '0;

  // Slot = every P-th edge with en high since the last reset.
  task automatic model(input logic r, input logic e, input logic [3:0] rq,
                       input logic [3:0] xx, input logic [63:0] dd);
    int j;
    logic [15:0] dw;
    if (r) begin
      m_en_cnt = 0; m_last = 3; m_idle = 0;
      m_ack = '0; m_upd = 1'b0; m_g = '0; m_a = '0; m_z = '0;
      return;
    end
    m_ack = '0;
    m_upd = 1'b0;
    if (e) begin
      m_en_cnt++;
      if (m_en_cnt % P == 0) begin
        if (rq == 4'b0000) begin
          m_idle = (m_idle < 255) ? m_idle + 1 : 255;
        end else begin
          j = -1;
          for (int k = 1; k <= 4; k++)
            if (j < 0 && rq[(m_last + k) % 4]) j = (m_last + k) % 4;
          dw     = dd[16*j +: 16];
          m_a    = xx[j] ? dw[11:8] : dw[15:12];
          m_z    = dw[7:0];
          m_g    = 2'(j);
          m_last = j;
          m_ack  = 4'(1 << j);
          m_upd  = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] rq,
                      input logic [3:0] xx, input logic [63:0] dd);
    exp_t rec;
    reset_     = r;
    en         = e;
    bus.req    = rq;
    bus.x      = xx;
    bus.d_bus  = dd;
    model(r, e, rq, xx, dd);
    rec.ack  = m_ack;
    rec.upd  = m_upd;
    rec.gnt  = m_g;
    rec.a    = m_a;
    rec.z    = m_z;
    rec.idle = 8'(m_idle);
    expq.push_back(rec);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      tests++;
      if (bus.ack !== e.ack || bus.upd !== e.upd || bus.gnt_id !== e.gnt ||
          bus.a3_a0 !== e.a || bus.z7_z0 !== e.z ||
          bus.idle_slots !== e.idle) begin
        fails++;
        $display("FAIL %s edge%0d: got ack=%b upd=%b gnt=%0d a=%h z=%h idle=%0d, want ack=%b upd=%b gnt=%0d a=%h z=%h idle=%0d",
                 phase, cyc, bus.ack, bus.upd, bus.gnt_id, bus.a3_a0,
                 bus.z7_z0, bus.idle_slots, e.ack, e.upd, e.gnt, e.a,
                 e.z, e.idle);
      end
    end
  end

  initial begin
    logic [63:0] d;

    phase = "reset";
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'(($urandom)), 4'b1111, 4'($urandom), rnd64());

    phase = "single_x0";
    d = rnd64();
    d[15:0] = 16'hA5C3;
    for (int i = 0; i < P; i++) step(1'b0, 1'b1, 4'b0001, 4'b1110, d);
    phase = "single_x1";
    for (int i = 0; i < P + 2; i++) step(1'b0, 1'b1, 4'b0001, 4'b0001, d);

    phase = "round_robin";
    step(1'b1, 1'b1, 4'b1111, 4'b0000, d);
    d = 64'h4D21_3C10_2B0F_1A0E;
    for (int i = 0; i < 5 * P + 2; i++)
      step(1'b0, 1'b1, 4'b1111, 4'($urandom), d);

    phase = "idle_sat";
    for (int i = 0; i < 300 * P; i++)
      step(1'b0, 1'b1, 4'b0000, 4'($urandom), rnd64());

    phase = "en_stall";
    step(1'b1, 1'b1, 4'b0000, 4'b0000, d);
    for (int i = 1; i <= 26; i++)
      step(1'b0, (i >= 8 && i <= 12) ? 1'b0 : 1'b1, 4'b0100,
           4'($urandom), rnd64());

    phase = "reset_mid_ack";
    step(1'b1, 1'b1, 4'b0000, 4'b0000, d);
    for (int i = 0; i < P; i++)
      step(1'b0, 1'b1, 4'b0010, 4'($urandom), rnd64());
    step(1'b1, 1'b1, 4'b0010, 4'($urandom), rnd64());
    for (int i = 0; i < P + 2; i++)
      step(1'b0, 1'b1, 4'b1111, 4'($urandom), rnd64());

    phase = "random";
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
           4'($urandom), 4'($urandom), rnd64());

    @(negedge clock);
    #1;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
